chunk_loader: RTL and testbench
===============================

// Module: chunk_loader
// PURPOSE
//  Upstream stage of led_controller. Receives a byte stream from the host interface,
//  frames it into row packets and writes 16 32-bit chunks per row into the panel
//  drivers via chunk_data/chunk_addr/chunk_write_enable/row_addr/panel_addr.
//  Resyncs on a sync byte; mid-packet stalls are aborted by an inter-byte timeout.
// PARAMETERS
//  SYNC_BYTE       8'hA5  packet start marker
//  TIMEOUT_CYCLES  1024   max clk cycles between accepted bytes inside a packet (>=2)
// PORTS
//  clk                 in   1   system clock
//  reset_n             in   1   asynchronous, active-low reset
//  rx_data             in   8   incoming byte
//  rx_valid            in   1   rx_data valid; byte accepted when rx_valid & rx_ready
//  rx_ready            out  1   byte acceptance
//  chunk_data          out  32  chunk payload to panel drivers
//  chunk_addr          out  4   chunk index within row (0..15)
//  chunk_write_enable  out  1   one-cycle write strobe
//  row_addr            out  4   target row of current packet
//  panel_addr          out  2   target panel of current packet
//  packet_done         out  1   one-cycle pulse after chunk 15 write (and checksum)
//  timeout_err         out  1   one-cycle pulse when a packet is aborted by timeout
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except rx_ready=1 (rx_ready is 0 only during reset).
//  Packet: SYNC_BYTE, header {2'b00, panel[1:0], row[3:0]}, 64 data bytes
//   (chunk 0..15, 4 bytes each, MSB first), [checksum byte if CHECKSUM_EN].
//  FSM: IDLE -(byte==SYNC_BYTE)-> HDR; other bytes in IDLE discarded silently.
//   HDR -(byte)-> DATA; latch panel_addr/row_addr; header bits [7:6] ignored; byte_cnt=0.
//   DATA: shift byte into 32-bit assembly reg; on 4th byte of a chunk, next cycle
//    chunk_write_enable=1 with chunk_data=assembled word, chunk_addr=chunk index;
//    chunk index wraps 15->0 only via packet end. After byte 63: -> IDLE (or CSUM).
//   CSUM (CHECKSUM_EN only): one byte, then -> IDLE.
//  Latency: accepted 4th byte at cycle N -> write strobe at N+1; packet_done at N+1 of
//   last chunk (no CHECKSUM_EN) or cycle after checksum byte accepted (CHECKSUM_EN).
//  chunk_data/chunk_addr/row_addr/panel_addr hold value after strobe until next write.
//  A SYNC_BYTE value inside HDR/DATA/CSUM is data, not a restart.
//  Timeout: in HDR/DATA/CSUM, counter clears on each accepted byte, counts otherwise;
//   reaching TIMEOUT_CYCLES -> IDLE, timeout_err pulse, partial chunk discarded (no
//   strobe); chunks already written are not undone. Counter idle in IDLE.
//  Byte accepted in same cycle as timeout expiry: byte wins, counter clears, no abort.
//  Async reset mid-packet: immediate return to IDLE, strobes/pulses drop to 0.
//  Back-to-back packets with rx_valid held high: no bubble; sync byte of next packet
//   may arrive in the cycle the previous packet_done pulses.
// CONFIGURATION
//  CHECKSUM_EN defined: packet carries trailing byte = XOR of header and 64 data bytes;
//   adds output csum_err (1 bit, one-cycle pulse with packet_done on mismatch);
//   packet_done still pulses; written chunks are not rolled back.
//  CHECKSUM_EN undefined: no CSUM state, no csum_err port, packet ends after byte 63.
// STRUCTURE
//  Shared package cube_pkg: loader state enum (IDLE,HDR,DATA,CSUM), SYNC_BYTE default,
//   CHUNKS_PER_ROW=16, BYTES_PER_CHUNK=4, chunk/row/panel address widths.
//  One sub-module: idle_timer (clear, enable, expired) for the inter-byte timeout.
// TESTING
//  1. Sync, hdr 8'h2B, bytes 00..3F -> 16 strobes, panel=2,row=11, chunk0=32'h00010203,
//     chunk15=32'h3C3D3E3F, chunk_addr 0..15 in order; one packet_done.
//  2. Garbage 11,22,A4 then valid packet -> garbage ignored, packet written normally.
//  3. Stall 1024 cycles after data byte 10 -> timeout_err, strobes only chunks 0..1,
//     FSM in IDLE; next full packet written correctly.
//  4. Two packets back-to-back, rx_valid constant 1 -> 32 strobes, 2 packet_done, no drop.
//  5. Reset asserted at data byte 30 -> outputs 0 at once; post-reset packet correct.
//  6. CHECKSUM_EN: correct XOR -> csum_err=0; flipped checksum -> csum_err pulse with
//     packet_done, all 16 chunks still written.

Source files
------------

// File: rtl/cube_pkg.sv
// cube_pkg: shared loader types and geometry for the LED cube datapath
package cube_pkg;
  typedef enum logic [1:0] {IDLE, HDR, DATA, CSUM} ld_state_t;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int CHUNKS_PER_ROW = 16;
  localparam int BYTES_PER_CHUNK = 4;
  localparam int CHUNK_AW = 4;
  localparam int ROW_AW = 4;
  localparam int PANEL_AW = 2;
  localparam int BYTE_CNT_W = $clog2(CHUNKS_PER_ROW * BYTES_PER_CHUNK);
endpackage

// File: rtl/idle_timer.sv
// idle_timer: counts idle cycles and flags expiry on the TIMEOUT_CYCLES-th one
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  logic [W-1:0] cnt;
  // a clear in the expiry cycle suppresses the flag so an arriving byte wins
  assign expired = enable & ~clear & (cnt == W'(TIMEOUT_CYCLES - 1));
  // idle-cycle counter, restarted by every clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
endmodule

// File: rtl/chunk_loader.sv
// chunk_loader: frames host bytes into row packets and writes 32-bit chunks; CHECKSUM_EN adds a trailing XOR byte and csum_err
module chunk_loader
  import cube_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [31:0]         chunk_data,
  output logic [CHUNK_AW-1:0] chunk_addr,
  output logic                chunk_write_enable,
  output logic [ROW_AW-1:0]   row_addr,
  output logic [PANEL_AW-1:0] panel_addr,
  output logic                packet_done,
  output logic                timeout_err
`ifdef CHECKSUM_EN
  ,
  output logic                csum_err
`endif
);
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(CHUNKS_PER_ROW * BYTES_PER_CHUNK - 1);
  localparam logic [1:0] CHUNK_END = 2'(BYTES_PER_CHUNK - 1);
`ifdef CHECKSUM_EN
  localparam ld_state_t AFTER_DATA = CSUM;
  logic [7:0] csum;
`else
  localparam ld_state_t AFTER_DATA = IDLE;
`endif
  ld_state_t state, nxt;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [23:0] asm_q;
  logic accept, abort, last;
  assign accept = rx_valid & rx_ready;
  assign last = byte_cnt == LAST_BYTE;
  idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (accept | (state == IDLE)),
    .enable (state != IDLE),
    .expired(abort)
  );
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  // next-state: a sync byte opens a packet; later bytes are payload regardless of value
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = (accept && rx_data == SYNC_BYTE) ? HDR : IDLE;
      HDR:  nxt = accept ? DATA : abort ? IDLE : HDR;
      DATA: nxt = accept ? (last ? AFTER_DATA : DATA) : abort ? IDLE : DATA;
      default: nxt = (accept || abort) ? IDLE : state;
    endcase
  end
  // datapath: header latch, chunk assembly, strobes and pulses
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rx_ready <= 1'b0;
      chunk_data <= '0;
      chunk_addr <= '0;
      chunk_write_enable <= 1'b0;
      row_addr <= '0;
      panel_addr <= '0;
      packet_done <= 1'b0;
      timeout_err <= 1'b0;
      byte_cnt <= '0;
      asm_q <= '0;
`ifdef CHECKSUM_EN
      csum <= '0;
      csum_err <= 1'b0;
`endif
    end else begin
      rx_ready <= 1'b1;
      chunk_write_enable <= 1'b0;
      packet_done <= 1'b0;
      timeout_err <= abort;
`ifdef CHECKSUM_EN
      csum_err <= 1'b0;
`endif
      if (accept && state == HDR) begin
        panel_addr <= rx_data[5:4];
        row_addr <= rx_data[3:0];
        byte_cnt <= '0;
`ifdef CHECKSUM_EN
        csum <= rx_data;
`endif
      end
      if (accept && state == DATA) begin
        asm_q <= {asm_q[15:0], rx_data};
        byte_cnt <= byte_cnt + 1'b1;
`ifdef CHECKSUM_EN
        csum <= csum ^ rx_data;
`else
        packet_done <= last;
`endif
        if (byte_cnt[1:0] == CHUNK_END) begin
          chunk_data <= {asm_q, rx_data};
          chunk_addr <= byte_cnt[BYTE_CNT_W-1:2];
          chunk_write_enable <= 1'b1;
        end
      end
`ifdef CHECKSUM_EN
      if (accept && state == CSUM) begin
        packet_done <= 1'b1;
        csum_err <= csum != rx_data;
      end
`endif
    end
endmodule

// File: tb/tb_chunk_loader.sv
// tb_chunk_loader: scoreboard bench for chunk_loader; honours CHECKSUM_EN
module tb_chunk_loader;
  logic clk = 0, reset_n = 0, rx_valid = 0, rx_ready;
  logic [7:0] rx_data = 0;
  logic [31:0] chunk_data;
  logic [3:0] chunk_addr, row_addr;
  logic [1:0] panel_addr;
  logic chunk_write_enable, packet_done, timeout_err;
`ifdef CHECKSUM_EN
  logic csum_err;
`endif
  typedef struct {logic [3:0] a; logic [31:0] d; logic [3:0] r; logic [1:0] p;} wr_t;
  wr_t wq[$];
  bit dq[$];
  int to_pend = 0, checks = 0, errors = 0;

  chunk_loader dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .chunk_data(chunk_data), .chunk_addr(chunk_addr), .chunk_write_enable(chunk_write_enable),
    .row_addr(row_addr), .panel_addr(panel_addr), .packet_done(packet_done), .timeout_err(timeout_err)
`ifdef CHECKSUM_EN
    , .csum_err(csum_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chunk_write_enable) begin
      chk("strobe_expected", wq.size() != 0, 1);
      if (wq.size() != 0) begin
        wr_t w;
        w = wq.pop_front();
        chk("chunk_addr", chunk_addr, w.a);
        chk("chunk_data", chunk_data, w.d);
        chk("row_addr", row_addr, w.r);
        chk("panel_addr", panel_addr, w.p);
      end
    end
    if (packet_done) begin
      chk("done_expected", dq.size() != 0, 1);
      if (dq.size() != 0) begin
        bit e;
        e = dq.pop_front();
`ifdef CHECKSUM_EN
        chk("csum_err", csum_err, e);
`endif
      end
    end
    if (timeout_err) begin
      chk("timeout_expected", to_pend > 0, 1);
      if (to_pend > 0) to_pend--;
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pkt(input logic [7:0] hdr, input logic [7:0] base, input int ndata,
                     input int stall_at, input int stall_len, input bit flip);
    logic [7:0] cs, b;
    wr_t w;
    cs = hdr;
    for (int i = 0; i < ndata / 4; i++) begin
      w.a = 4'(i);
      w.d = {8'(base + 4 * i), 8'(base + 4 * i + 1), 8'(base + 4 * i + 2), 8'(base + 4 * i + 3)};
      w.r = hdr[3:0];
      w.p = hdr[5:4];
      wq.push_back(w);
    end
    if (ndata == 64) dq.push_back(flip);
    send(8'hA5);
    send(hdr);
    for (int i = 0; i < ndata; i++) begin
      b = 8'(base + i);
      cs ^= b;
      send(b);
      if (i == stall_at) idle(stall_len);
    end
`ifdef CHECKSUM_EN
    if (ndata == 64) send(flip ? ~cs : cs);
`else
    if (flip) cs = 0;
`endif
  endtask

  task automatic drain();
    idle(4);
    chk("pending_writes", wq.size(), 0);
    chk("pending_done", dq.size(), 0);
    chk("pending_timeout", to_pend, 0);
  endtask

  initial begin
    #2;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_we", chunk_write_enable, 0);
    chk("rst_data", chunk_data, 0);
    chk("rst_done", packet_done, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", rx_ready, 1);
    pkt(8'h2B, 8'h00, 64, -1, 0, 0);
    drain();
    send(8'h11); send(8'h22); send(8'hA4);
    pkt(8'hC7, 8'h40, 64, -1, 0, 0);
    drain();
    pkt(8'h15, 8'h80, 64, 5, 1023, 0);
    drain();
    to_pend = 1;
    pkt(8'h31, 8'h10, 11, -1, 0, 0);
    idle(1030);
    chk("timeout_seen", to_pend, 0);
    pkt(8'h0E, 8'hA5, 64, -1, 0, 0);
    drain();
    pkt(8'h23, 8'h00, 64, -1, 0, 0);
    pkt(8'h1F, 8'hC0, 64, -1, 0, 0);
    drain();
    pkt(8'h36, 8'h20, 30, -1, 0, 0);
    rx_valid = 0;
    reset_n = 0;
    #1;
    chk("async_rst_we", chunk_write_enable, 0);
    chk("async_rst_data", chunk_data, 0);
    chk("async_rst_addr", {row_addr, panel_addr, chunk_addr}, 0);
    chk("async_rst_ready", rx_ready, 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1;
    idle(2);
    pkt(8'h24, 8'h60, 64, -1, 0, 0);
    drain();
`ifdef CHECKSUM_EN
    pkt(8'h19, 8'h33, 64, -1, 0, 1);
    drain();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
